// File: rtl/onedconv_buffer_loader_if.sv
// Bus between the 1-D conv buffer loader, its IFMAP/weight BRAMs and the lane buffers.
interface onedconv_buffer_loader_if #(
  parameter int unsigned DW        = 16,
  parameter int unsigned Dimension = 16,
  parameter int unsigned ADDR_W    = 10
);
  logic                    start;
  logic [ADDR_W-1:0]       ifmap_base_addr;
  logic [ADDR_W-1:0]       weight_base_addr;
  logic                    ifmap_bram_en;
  logic [ADDR_W-1:0]       ifmap_bram_addr;
  logic [DW-1:0]           ifmap_bram_rdata;
  logic                    weight_bram_en;
  logic [ADDR_W-1:0]       weight_bram_addr;
  logic [Dimension*DW-1:0] weight_bram_rdata;
  logic [DW-1:0]           ifmap_serial_in;
  logic [Dimension*DW-1:0] weight_brams_in;
  logic [Dimension-1:0]    en_shift_reg_ifmap_input;
  logic [Dimension-1:0]    en_shift_reg_weight_input;
  logic                    mode;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, ifmap_base_addr, weight_base_addr, ifmap_bram_rdata, weight_bram_rdata,
    output ifmap_bram_en, ifmap_bram_addr, weight_bram_en, weight_bram_addr,
           ifmap_serial_in, weight_brams_in, en_shift_reg_ifmap_input,
           en_shift_reg_weight_input, mode, busy, done
  );

  modport slave (
    output start, ifmap_base_addr, weight_base_addr, ifmap_bram_rdata, weight_bram_rdata,
    input  ifmap_bram_en, ifmap_bram_addr, weight_bram_en, weight_bram_addr,
           ifmap_serial_in, weight_brams_in, en_shift_reg_ifmap_input,
           en_shift_reg_weight_input, mode, busy, done
  );
endinterface

// File: rtl/onedconv_buffer_loader.sv
// Sequences IFMAP and weight BRAM reads into the per-lane input shift buffers,
// inserting a leading zero-pad word per lane, then hands over via mode.
module onedconv_buffer_loader #(
  parameter int unsigned DW        = 16,
  parameter int unsigned Dimension = 16,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  onedconv_buffer_loader_if.master   bus
);

  localparam int unsigned LANE_W = (Dimension > 1) ? $clog2(Dimension) : 1;
  localparam int unsigned K_W    = $clog2(Dimension + 1);
  localparam int unsigned WBUS_W = Dimension * DW;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IFMAP,
    LOAD_WEIGHT,
    DRAIN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [ADDR_W-1:0]    ibase_q, ibase_d;
  logic [ADDR_W-1:0]    wbase_q, wbase_d;
  logic                 ifmap_en_q, ifmap_en_d;
  logic [ADDR_W-1:0]    ifmap_addr_q, ifmap_addr_d;
  logic                 weight_en_q, weight_en_d;
  logic [ADDR_W-1:0]    weight_addr_q, weight_addr_d;
  logic [Dimension-1:0] shift_i_q, shift_i_d;
  logic                 pad_i_q, pad_i_d;
  logic                 shift_w_q, shift_w_d;
  logic                 pad_w_q, pad_w_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lane_q        <= '0;
      k_q           <= '0;
      ibase_q       <= '0;
      wbase_q       <= '0;
      ifmap_en_q    <= 1'b0;
      ifmap_addr_q  <= '0;
      weight_en_q   <= 1'b0;
      weight_addr_q <= '0;
      shift_i_q     <= '0;
      pad_i_q       <= 1'b0;
      shift_w_q     <= 1'b0;
      pad_w_q       <= 1'b0;
      mode_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      k_q           <= k_d;
      ibase_q       <= ibase_d;
      wbase_q       <= wbase_d;
      ifmap_en_q    <= ifmap_en_d;
      ifmap_addr_q  <= ifmap_addr_d;
      weight_en_q   <= weight_en_d;
      weight_addr_q <= weight_addr_d;
      shift_i_q     <= shift_i_d;
      pad_i_q       <= pad_i_d;
      shift_w_q     <= shift_w_d;
      pad_w_q       <= pad_w_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Slot sequencing; BRAM reads are registered from the next slot so that
  // the read of a slot is presented in the same cycle the slot is issued.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    k_d     = k_q;
    ibase_d = ibase_q;
    wbase_d = wbase_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_IFMAP;
          lane_d  = '0;
          k_d     = '0;
          ibase_d = bus.ifmap_base_addr;
          wbase_d = bus.weight_base_addr;
          mode_d  = 1'b0;
        end
      end
      LOAD_IFMAP: begin
        if (k_q == K_W'(Dimension)) begin
          k_d = '0;
          if (lane_q == LANE_W'(Dimension - 1)) begin
            state_d = LOAD_WEIGHT;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      LOAD_WEIGHT: begin
        if (k_q == K_W'(Dimension)) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) begin
      mode_d = 1'b1;
    end

    ifmap_en_d    = (state_d == LOAD_IFMAP) && (k_d != '0);
    ifmap_addr_d  = ifmap_en_d
                  ? ibase_d + ADDR_W'(lane_d) * ADDR_W'(Dimension) + ADDR_W'(k_d) - ADDR_W'(1)
                  : '0;
    weight_en_d   = (state_d == LOAD_WEIGHT) && (k_d != '0);
    weight_addr_d = weight_en_d ? wbase_d + ADDR_W'(k_d) - ADDR_W'(1) : '0;

    // Shift enables lag the issued slot by the one-cycle read latency.
    shift_i_d = '0;
    if (state_q == LOAD_IFMAP) begin
      shift_i_d[lane_q] = 1'b1;
    end
    pad_i_d   = (state_q == LOAD_IFMAP) && (k_q == '0);
    shift_w_d = (state_q == LOAD_WEIGHT);
    pad_w_d   = shift_w_d && (k_q == '0);

    busy_d = (state_d == LOAD_IFMAP) || (state_d == LOAD_WEIGHT) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  assign bus.ifmap_bram_en             = ifmap_en_q;
  assign bus.ifmap_bram_addr           = ifmap_addr_q;
  assign bus.weight_bram_en            = weight_en_q;
  assign bus.weight_bram_addr          = weight_addr_q;
  assign bus.en_shift_reg_ifmap_input  = shift_i_q;
  assign bus.en_shift_reg_weight_input = {Dimension{shift_w_q}};
  assign bus.mode                      = mode_q;
  assign bus.busy                      = busy_q;
  assign bus.done                      = done_q;

  // Read data passes straight through on data slots; pad slots and idle cycles give zero.
  assign bus.ifmap_serial_in = ((|shift_i_q) && !pad_i_q) ? bus.ifmap_bram_rdata  : DW'(0);
  assign bus.weight_brams_in = (shift_w_q && !pad_w_q)    ? bus.weight_bram_rdata : WBUS_W'(0);

endmodule

// File: tb/tb_onedconv_buffer_loader.sv
// Scoreboard bench for onedconv_buffer_loader: a 4-lane and a 16-lane instance.
module tb_onedconv_buffer_loader;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [15:0]  en_i;
    logic [15:0]  en_w;
    logic [15:0]  ser;
    logic [255:0] wd;
    logic         done;
    logic         mode;
    logic         busy;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = 32'd0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cnt_i4 = 0, cnt_w4 = 0, cnt_i16 = 0, cnt_w16 = 0;
  ev_t         q4[$];
  ev_t         q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  onedconv_buffer_loader_if #(.DW(16), .Dimension(4),  .ADDR_W(10)) bus4 ();
  onedconv_buffer_loader_if #(.DW(16), .Dimension(16), .ADDR_W(10)) bus16 ();

  onedconv_buffer_loader #(.DW(16), .Dimension(4),  .ADDR_W(10)) dut4  (.clk(clk), .rst(rst), .bus(bus4.master));
  onedconv_buffer_loader #(.DW(16), .Dimension(16), .ADDR_W(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16.master));

  // BRAM models: IFMAP data = address, weight lane j = address + j, one-cycle latency.
  always @(posedge clk) begin
    if (bus4.ifmap_bram_en) bus4.ifmap_bram_rdata <= 16'(bus4.ifmap_bram_addr);
    if (bus4.weight_bram_en)
      for (int j = 0; j < 4; j++) bus4.weight_bram_rdata[j*16 +: 16] <= 16'(bus4.weight_bram_addr) + 16'(j);
    if (bus16.ifmap_bram_en) bus16.ifmap_bram_rdata <= 16'(bus16.ifmap_bram_addr);
    if (bus16.weight_bram_en)
      for (int j = 0; j < 16; j++) bus16.weight_bram_rdata[j*16 +: 16] <= 16'(bus16.weight_bram_addr) + 16'(j);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cmp_ev(input string name, input ev_t exp, input ev_t act);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cyc=%0d en_i=%h en_w=%h ser=%h done/mode/busy=%b%b%b wd=%h, expected cyc=%0d en_i=%h en_w=%h ser=%h done/mode/busy=%b%b%b wd=%h",
                  name, act.cyc, act.en_i, act.en_w, act.ser, act.done, act.mode, act.busy, act.wd,
                  exp.cyc, exp.en_i, exp.en_w, exp.ser, exp.done, exp.mode, exp.busy, exp.wd);
  endtask

  // Expected events of one load, dropping those after cycle 'last' (reset abort).
  task automatic push_load(input bit big, input logic [31:0] c1, input logic [9:0] ib,
                           input logic [9:0] wb, input logic [31:0] last);
    int d = big ? 16 : 4;
    ev_t e;
    for (int n = 0; n < d * (d + 1); n++) begin
      int lane = n / (d + 1);
      int k    = n % (d + 1);
      e       = '0;
      e.cyc   = c1 + 32'(n) + 32'd1;
      e.en_i  = 16'(1) << lane;
      e.ser   = (k == 0) ? 16'd0 : 16'(10'(ib + 10'(lane * d + k - 1)));
      e.busy  = 1'b1;
      if (e.cyc <= last) begin if (big) q16.push_back(e); else q4.push_back(e); end
    end
    for (int m = 0; m <= d; m++) begin
      e      = '0;
      e.cyc  = c1 + 32'(d * (d + 1) + 1 + m);
      e.en_w = big ? 16'hFFFF : 16'h000F;
      for (int j = 0; j < d; j++)
        e.wd[j*16 +: 16] = (m == 0) ? 16'd0 : 16'(10'(wb + 10'(m - 1))) + 16'(j);
      e.busy = 1'b1;
      if (e.cyc <= last) begin if (big) q16.push_back(e); else q4.push_back(e); end
    end
    e      = '0;
    e.cyc  = c1 + 32'(d * (d + 1) + d + 2);
    e.done = 1'b1;
    e.mode = 1'b1;
    if (e.cyc <= last) begin if (big) q16.push_back(e); else q4.push_back(e); end
  endtask

  // Monitors: any enable or done is an output event checked against the queue head.
  always @(negedge clk) begin
    ev_t a, e;
    if (bus4.en_shift_reg_ifmap_input != '0 || bus4.en_shift_reg_weight_input != '0 || bus4.done) begin
      a = '0;
      a.cyc = cyc; a.en_i = 16'(bus4.en_shift_reg_ifmap_input); a.en_w = 16'(bus4.en_shift_reg_weight_input);
      a.ser = bus4.ifmap_serial_in; a.wd = 256'(bus4.weight_brams_in);
      a.done = bus4.done; a.mode = bus4.mode; a.busy = bus4.busy;
      if (a.en_i != 0) cnt_i4++;
      if (a.en_w != 0) cnt_w4++;
      if (q4.size() == 0) begin
        n_checks++;
        $display("FAIL ev4_unexpected: got event at cycle %0d en_i=%h en_w=%h done=%b, expected none", cyc, a.en_i, a.en_w, a.done);
      end else begin
        e = q4.pop_front();
        cmp_ev("ev4", e, a);
      end
    end
  end

  always @(negedge clk) begin
    ev_t a, e;
    if (bus16.en_shift_reg_ifmap_input != '0 || bus16.en_shift_reg_weight_input != '0 || bus16.done) begin
      a = '0;
      a.cyc = cyc; a.en_i = bus16.en_shift_reg_ifmap_input; a.en_w = bus16.en_shift_reg_weight_input;
      a.ser = bus16.ifmap_serial_in; a.wd = bus16.weight_brams_in;
      a.done = bus16.done; a.mode = bus16.mode; a.busy = bus16.busy;
      if (a.en_i != 0) cnt_i16++;
      if (a.en_w != 0) cnt_w16++;
      if (q16.size() == 0) begin
        n_checks++;
        $display("FAIL ev16_unexpected: got event at cycle %0d en_i=%h en_w=%h done=%b, expected none", cyc, a.en_i, a.en_w, a.done);
      end else begin
        e = q16.pop_front();
        cmp_ev("ev16", e, a);
      end
    end
  end

  task automatic wait_cyc(input logic [31:0] c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic chk_idle4(input string tag);
    chk(tag, 64'({bus4.en_shift_reg_ifmap_input, bus4.en_shift_reg_weight_input, bus4.ifmap_bram_en,
                  bus4.weight_bram_en, bus4.busy, bus4.mode, bus4.done, bus4.ifmap_bram_addr,
                  bus4.weight_bram_addr, bus4.ifmap_serial_in}), 64'd0);
  endtask

  task automatic chk_idle16(input string tag);
    chk(tag, 64'({bus16.en_shift_reg_ifmap_input, bus16.en_shift_reg_weight_input, bus16.ifmap_bram_en,
                  bus16.weight_bram_en, bus16.busy, bus16.mode, bus16.done, bus16.ifmap_bram_addr,
                  bus16.weight_bram_addr}), 64'd0);
  endtask

  // Issues a one-cycle start in the current cycle; returns C1 and leaves us in cycle C1.
  task automatic start_load(input bit big, input logic [9:0] ib, input logic [9:0] wb,
                            input int unsigned keep, output logic [31:0] c1);
    c1 = cyc + 32'd1;
    push_load(big, c1, ib, wb, c1 + 32'(keep));
    if (big) begin
      bus16.start = 1'b1; bus16.ifmap_base_addr = ib; bus16.weight_base_addr = wb;
    end else begin
      bus4.start = 1'b1; bus4.ifmap_base_addr = ib; bus4.weight_base_addr = wb;
    end
    @(posedge clk); #1;
    bus4.start = 1'b0; bus16.start = 1'b0;
    bus4.ifmap_base_addr = ~ib;  bus4.weight_base_addr = ~wb;
    bus16.ifmap_base_addr = ~ib; bus16.weight_base_addr = ~wb;
  endtask

  initial begin
    logic [31:0] c1, c1b;
    bus4.start = 1'b1;  bus4.ifmap_base_addr = 10'h155;  bus4.weight_base_addr = 10'h0AA;
    bus16.start = 1'b1; bus16.ifmap_base_addr = 10'h155; bus16.weight_base_addr = 10'h0AA;

    // Reset held with start asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle4($sformatf("reset4_c%0d", i));
      chk_idle16($sformatf("reset16_c%0d", i));
    end
    rst = 1'b0; bus4.start = 1'b0; bus16.start = 1'b0;
    @(posedge clk); #1;
    chk_idle4("idle4_after_reset");

    // Plain 4-lane load.
    start_load(1'b0, 10'h010, 10'h100, 1000, c1);
    chk("busy4_at_c1", 64'(bus4.busy), 64'd1);
    wait_cyc(c1 + 32'd27);
    chk("cnt_ifmap4", 64'(cnt_i4), 64'd20);
    chk("cnt_weight4", 64'(cnt_w4), 64'd5);
    chk("mode4_after_done", 64'({bus4.mode, bus4.busy, bus4.done}), 64'b100);
    wait_cyc(c1 + 32'd30);
    chk("mode4_held_idle", 64'(bus4.mode), 64'd1);

    // Second load with ignored start and address wrap-around.
    start_load(1'b0, 10'h3FC, 10'h3FE, 1000, c1);
    chk("mode4_cleared_at_c1", 64'(bus4.mode), 64'd0);
    wait_cyc(c1 + 32'd7);
    bus4.start = 1'b1; bus4.ifmap_base_addr = 10'h200;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    wait_cyc(c1 + 32'd28);

    // Reset in the middle of a load, then a full load.
    start_load(1'b0, 10'h020, 10'h200, 10, c1);
    wait_cyc(c1 + 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle4("abort4_after_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle4("abort4_stays_idle");
    start_load(1'b0, 10'h030, 10'h300, 1000, c1);
    wait_cyc(c1 + 32'd27);
    chk("mode4_after_reload", 64'(bus4.mode), 64'd1);

    // 16-lane back-to-back loads.
    start_load(1'b1, 10'h040, 10'h080, 1000, c1);
    wait_cyc(c1 + 32'd291);
    chk("mode16_before_restart", 64'(bus16.mode), 64'd1);
    start_load(1'b1, 10'h123, 10'h0F0, 1000, c1b);
    chk("c1b_offset", 64'(c1b - c1), 64'd292);
    chk("mode16_cleared_at_c1", 64'({bus16.mode, bus16.busy}), 64'b01);
    wait_cyc(c1b + 32'd292);
    chk("cnt_ifmap16", 64'(cnt_i16), 64'd544);
    chk("cnt_weight16", 64'(cnt_w16), 64'd34);

    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onedconv_buffer_loader.md
Name: onedconv_buffer_loader

Overview:
- Upstream sequencer for the 1-D conv input buffer stage (per-lane IFMAP/weight shift registers, depth Dimension+1).
- On start, reads the IFMAP BRAM serially and the Dimension parallel weight BRAMs, and produces the serial data plus per-lane shift enables for the input phase.
- Inserts the leading zero-pad word into every lane. Raises `mode` when the buffers are full so the downstream control logic takes over.

Parameters:
- DW, 16, data word width.
- Dimension, 16, number of lanes. Each lane register holds Dimension+1 words.
- ADDR_W, 10, BRAM address width.

Ports:
- clk  in  1  single clock; all outputs registered on posedge (buffers shift on negedge, so data is stable).
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle load request. Honoured only in IDLE.
- ifmap_base_addr  in  ADDR_W  IFMAP BRAM base, sampled on accepted start.
- weight_base_addr  in  ADDR_W  weight BRAM base, sampled on accepted start.
- ifmap_bram_en  out  1  IFMAP BRAM read enable.
- ifmap_bram_addr  out  ADDR_W  IFMAP BRAM read address.
- ifmap_bram_rdata  in  DW  IFMAP read data, valid 1 cycle after en.
- weight_bram_en  out  1  weight BRAM read enable, shared by all lanes.
- weight_bram_addr  out  ADDR_W  weight read address, shared by all lanes.
- weight_bram_rdata  in  Dimension*DW  lane j on bits [(j+1)*DW-1 -: DW]. Valid 1 cycle after en.
- ifmap_serial_in  out  DW  serial IFMAP word to the buffers.
- weight_brams_in  out  Dimension*DW  parallel weight words to the buffers.
- en_shift_reg_ifmap_input  out  Dimension  one-hot lane enable.
- en_shift_reg_weight_input  out  Dimension  all-ones or zero.
- mode  out  1  0 = input phase, 1 = compute phase.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when load is complete.

Behaviour:
- **Reset values:** all outputs 0, including addresses, enables, mode, busy and done. FSM goes to IDLE. Reset mid-load aborts immediately; there is no further BRAM enable or shift enable from the next cycle.
- **FSM states:** IDLE, LOAD_IFMAP, LOAD_WEIGHT, DRAIN, DONE.
- **IDLE:** start=1 → LOAD_IFMAP. Latch both base addresses, clear mode, set busy. Let C1 be the first LOAD_IFMAP cycle.
- **Slot structure:** the issue stage runs one slot per cycle with no bubbles. The read pipeline is 1 cycle deep.
  - A slot issued in cycle t drives its shift enable and data in cycle t+1.
  - Data comes combinationally from rdata, or is forced to 0 for pad slots.
- **LOAD_IFMAP:** slots n = 0 .. Dimension*(Dimension+1)-1, with lane = n/(Dimension+1) and k = n mod (Dimension+1).
  - k=0 is the pad slot: no BRAM read, and ifmap_serial_in=0.
  - k>0 reads ifmap_base + lane*Dimension + (k-1).
  - en_shift_reg_ifmap_input is one-hot on that lane in cycle t+1.
  - Lanes are filled in order 0 → Dimension-1, so the pad word reaches each lane's output first.
- **LOAD_WEIGHT:** follows with no gap. Slots m = 0 .. Dimension.
  - m=0 is the pad slot: no read, and all lanes get 0.
  - m>0 reads weight_base + (m-1).
  - en_shift_reg_weight_input = all ones in cycle t+1.
- **IFMAP and weight enables** are never both nonzero in the same cycle. No enable is asserted outside these slots.
- **DRAIN:** 1 cycle, in which the last weight enable is driven.
- **DONE:** 1 cycle. done=1, mode=1, busy=0. Then → IDLE.
- **mode after load:** stays 1 in IDLE until the next accepted start.
- **Timing (default Dimension=16):**
  - IFMAP enables in cycles C1+1 .. C1+272.
  - Weight enables in cycles C1+273 .. C1+289.
  - done and mode rise at C1+290. busy is high C1 .. C1+289.
- **start handling:** start during busy, DRAIN or DONE is ignored. Base inputs may change freely after acceptance.
- **Address width:** address arithmetic is modulo 2^ADDR_W. Wrap-around is silent.
- **Reset priority:** rst has priority over start in the same cycle.

Test Plan:
- **Reset:** rst=1 for 3 cycles with start=1 → all outputs 0, no BRAM enable, stays IDLE.
- **IFMAP fill (Dimension=4):** base 0x010, BRAM model data = address.
  - Lane 0 receives 0, 0x010, 0x011, 0x012, 0x013 in cycles C1+1..C1+5 with en=4'b0001.
  - Lane 3 receives 0, 0x01C..0x01F with en=4'b1000.
  - Exactly 20 IFMAP enables in total.
- **Weight fill (Dimension=4):** base 0x100, lane j data = addr + j.
  - 5 enables of 4'b1111 immediately after the last IFMAP enable.
  - First word is all zero; lane 2 then sees 0x102..0x105.
  - done pulses once at C1+26, mode=1 afterwards.
- **Ignored start:** start pulsed at C1+7 → no restart, timing identical to the IFMAP fill case.
- **Reset mid-load:** rst at C1+10 → next cycle all enables, busy and mode are 0. A new start then completes a full normal load.
- **Default Dimension=16, back-to-back:** second start the cycle after done → mode clears to 0 at the new C1. 272 + 17 enables are counted, and done lands at C1+290 again.
